// File: rtl/vpu_wb_scheduler_pkg.sv
// Shared types and default widths for the VPU write-back scheduler.
package vpu_wb_scheduler_pkg;

    localparam int unsigned OPERAND_ADDR_WIDTH = 10;
    localparam int unsigned OPERAND_DATA_WIDTH = 32;
    localparam int unsigned WB_CNT_W           = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } wb_state_t;

endpackage

// File: rtl/vpu_wb_scheduler.sv
// VPU write-back scheduler: pairs WB FIFO addresses with execution results
// in order and issues one registered operand-buffer write per pair.
module vpu_wb_scheduler
    import vpu_wb_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = OPERAND_ADDR_WIDTH,
    parameter int unsigned DATA_W = OPERAND_DATA_WIDTH,
    parameter int unsigned CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_elem_i,
    input  logic              reset_cmd_i,
    output logic              done_o,
    output logic              busy_o,
    output logic              err_o,
    input  logic              af_empty_i,
    output logic              af_rden_o,
    input  logic [ADDR_W-1:0] af_rdata_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              res_ready_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic              wr_ready_i
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_done;
    logic              r_err;
    logic              w_done_nxt;
    logic              w_af_rden;
    logic              w_fire;
    logic              w_wr_accept;

    // An abort in the same cycle suppresses pairing so nothing new enters the output stage.
    assign w_wr_accept = r_wr_valid & wr_ready_i;
    assign w_fire      = (r_state == S_RUN) & ~reset_cmd_i & res_valid_i & ~af_empty_i
                       & (~r_wr_valid | wr_ready_i) & (r_cnt != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, FIFO pop and done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_af_rden   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (num_elem_i != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (reset_cmd_i) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_af_rden = w_fire;
                    if (w_fire && r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (reset_cmd_i) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_wr_accept) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_FLUSH: begin
                w_af_rden = ~af_empty_i;
                if (af_empty_i) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Remaining element count: latched on start, decremented per accepted pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_cnt <= num_elem_i;
        end else if (w_fire) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (w_state_nxt == S_FLUSH) begin
            r_cnt <= '0;
        end
    end

    // One-entry output stage: load on fire, hold under backpressure, drop on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            if (w_state_nxt == S_FLUSH) begin
                r_wr_valid <= 1'b0;
            end else if (w_fire) begin
                r_wr_valid <= 1'b1;
            end else if (w_wr_accept) begin
                r_wr_valid <= 1'b0;
            end
            if (w_fire) begin
                r_wr_addr <= af_rdata_i;
                r_wr_data <= res_data_i;
            end
        end
    end

    // Done pulse and sticky underflow flag (cleared by any accepted start).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (r_state == S_IDLE && start_i) begin
                r_err <= 1'b0;
            end else if (r_state == S_RUN && res_valid_i && af_empty_i) begin
                r_err <= 1'b1;
            end
        end
    end

    assign done_o      = r_done;
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
    assign af_rden_o   = w_af_rden;
    assign res_ready_o = w_fire;
    assign wr_valid_o  = r_wr_valid;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;

endmodule

// File: tb/tb_vpu_wb_scheduler.sv
// Scoreboard bench for vpu_wb_scheduler: the stimulus side posts expected
// (addr,data) pairs; a negedge monitor pops and compares on every write.
module tb_vpu_wb_scheduler;
    import vpu_wb_scheduler_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] num_elem_i;
    logic          reset_cmd_i;
    logic          done_o, busy_o, err_o;
    logic          af_empty_i, af_rden_o;
    logic [AW-1:0] af_rdata_i;
    logic          res_valid_i, res_ready_o;
    logic [DW-1:0] res_data_i;
    logic          wr_valid_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_ready_i;

    vpu_wb_scheduler #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_elem_i(num_elem_i),
        .reset_cmd_i(reset_cmd_i), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .af_empty_i(af_empty_i), .af_rden_o(af_rden_o), .af_rdata_i(af_rdata_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o),
        .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_ready_i(wr_ready_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pairs (written by stimulus, consumed by monitor).
    logic [AW-1:0] exp_a [2048];
    logic [DW-1:0] exp_d [2048];
    int unsigned   exp_wr = 0;
    int unsigned   exp_rd = 0;

    // Point checks posted by the stimulus side, evaluated by the monitor.
    string         chk_name [1024];
    logic [63:0]   chk_act  [1024];
    logic [63:0]   chk_req  [1024];
    int unsigned   chk_wr = 0;
    int unsigned   chk_rd = 0;

    // Environment: WB address FIFO and result stream models.
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] data_q [$];
    bit            res_rand = 1'b0;
    bit            wr_rand  = 1'b0;
    int unsigned   wr_hold_low = 0;

    // Monitor-owned state.
    int            total = 0;
    int            bad   = 0;
    bit            s_pop = 1'b0;
    bit            s_res = 1'b0;
    int unsigned   wr_cnt = 0;
    int unsigned   pop_cnt = 0;
    int unsigned   done_cnt = 0;
    int unsigned   done_cyc = 0;
    int unsigned   fire_cyc_q [$];
    int unsigned   wr_cyc_q [$];
    bit            stall_prev = 1'b0;
    bit            done_prev  = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    task automatic mon_cmp(input string n, input logic [63:0] a, input logic [63:0] r);
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, r, cyc);
        end
    endtask

    // Monitor: evaluate posted checks, score writes, check protocol rules.
    always @(negedge clk) begin
        while (chk_rd != chk_wr) begin
            mon_cmp(chk_name[chk_rd], chk_act[chk_rd], chk_req[chk_rd]);
            chk_rd++;
        end
        if (rst) begin
            s_pop      = 1'b0;
            s_res      = 1'b0;
            stall_prev = 1'b0;
            done_prev  = 1'b0;
            exp_rd     = exp_wr;
        end else begin
            s_pop = af_rden_o;
            s_res = res_valid_i & res_ready_o;
            if (af_rden_o) begin
                pop_cnt++;
                mon_cmp("pop_when_empty", {63'd0, af_empty_i}, 64'd0);
            end
            if (s_res) fire_cyc_q.push_back(cyc);
            if (stall_prev) begin
                mon_cmp("stall_valid_held", {63'd0, wr_valid_o}, 64'd1);
                mon_cmp("stall_addr_stable", {54'd0, wr_addr_o}, {54'd0, prev_addr});
                mon_cmp("stall_data_stable", {32'd0, wr_data_o}, {32'd0, prev_data});
            end
            if (wr_valid_o && !wr_ready_i) begin
                mon_cmp("stall_res_ready", {63'd0, res_ready_o}, 64'd0);
            end
            if (wr_valid_o && wr_ready_i) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                if (exp_rd == exp_wr) begin
                    mon_cmp("unexpected_write", {54'd0, wr_addr_o}, 64'd0 - 64'd1);
                end else begin
                    mon_cmp("wr_addr", {54'd0, wr_addr_o}, {54'd0, exp_a[exp_rd]});
                    mon_cmp("wr_data", {32'd0, wr_data_o}, {32'd0, exp_d[exp_rd]});
                    exp_rd++;
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                mon_cmp("done_pulse_width", {63'd0, done_prev}, 64'd0);
                mon_cmp("done_pending_pairs", 64'(exp_wr - exp_rd), 64'd0);
            end
            stall_prev = wr_valid_o && !wr_ready_i;
            done_prev  = done_o;
            prev_addr  = wr_addr_o;
            prev_data  = wr_data_o;
        end
    end

    task automatic post(input string n, input logic [63:0] a, input logic [63:0] r);
        chk_name[chk_wr] = n;
        chk_act[chk_wr]  = a;
        chk_req[chk_wr]  = r;
        chk_wr++;
    endtask

    task automatic drive();
        af_empty_i  = (addr_q.size() == 0);
        af_rdata_i  = (addr_q.size() != 0) ? addr_q[0] : '0;
        res_valid_i = (data_q.size() != 0) && (!res_rand || $urandom_range(0, 3) != 0);
        res_data_i  = (data_q.size() != 0) ? data_q[0] : '0;
        if (wr_hold_low != 0) begin
            wr_ready_i = 1'b0;
            wr_hold_low--;
        end else begin
            wr_ready_i = !wr_rand || ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_pop && addr_q.size() != 0) void'(addr_q.pop_front());
        if (s_res && data_q.size() != 0) void'(data_q.pop_front());
        drive();
    endtask

    // Generate n random pairs: all n addresses go to the FIFO, first n_res results to the stream.
    task automatic load_cmd(input int unsigned n, input int unsigned n_res);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int unsigned i = 0; i < n; i++) begin
            a = AW'($urandom);
            d = $urandom;
            addr_q.push_back(a);
            if (i < n_res) begin
                data_q.push_back(d);
                exp_a[exp_wr] = a;
                exp_d[exp_wr] = d;
                exp_wr++;
            end
        end
    endtask

    task automatic start_cmd(input int unsigned n);
        start_i    = 1'b1;
        num_elem_i = CW'(n);
        tick();
        start_i    = 1'b0;
    endtask

    task automatic run_until_done(input int unsigned budget, input int unsigned stall_at);
        int unsigned d0 = done_cnt;
        int unsigned w0 = wr_cnt;
        int unsigned n  = 0;
        bit          stalled = 1'b0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
            if (stall_at != 0 && !stalled && wr_cnt == w0 + stall_at) begin
                wr_ready_i  = 1'b0;
                wr_hold_low = 1;
                stalled     = 1'b1;
            end
        end
        if (done_cnt == d0) post("done_timeout", 64'd0, 64'd1);
        if (stall_at != 0) post("stall_applied", {63'd0, stalled}, 64'd1);
    endtask

    initial begin
        int unsigned fb, wb, w0, p0, n;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;

        rst = 1'b1; start_i = 1'b0; num_elem_i = '0; reset_cmd_i = 1'b0;
        drive();
        repeat (3) tick();
        post("rst_busy", {63'd0, busy_o}, 64'd0);
        post("rst_done", {63'd0, done_o}, 64'd0);
        post("rst_wr_valid", {63'd0, wr_valid_o}, 64'd0);
        post("rst_err", {63'd0, err_o}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: four back-to-back pairs, no backpressure.
        fb = fire_cyc_q.size();
        wb = wr_cyc_q.size();
        load_cmd(4, 4);
        start_cmd(4);
        run_until_done(200, 0);
        post("t1_write_count", 64'(wr_cyc_q.size() - wb), 64'd4);
        if (wr_cyc_q.size() >= wb + 4 && fire_cyc_q.size() > fb) begin
            for (int unsigned i = 0; i < 4; i++)
                post("t1_write_cycle", 64'(wr_cyc_q[wb+i]), 64'(fire_cyc_q[fb] + 1 + i));
            post("t1_done_cycle", 64'(done_cyc), 64'(wr_cyc_q[wb+3] + 1));
        end
        post("t1_busy_after", {63'd0, busy_o}, 64'd0);

        // 2: backpressure on the second write.
        load_cmd(3, 3);
        start_cmd(3);
        run_until_done(200, 1);

        // 3: results arrive before any address -> underflow flagged, stall without loss.
        a0 = AW'($urandom);
        d0 = $urandom;
        exp_a[exp_wr] = a0; exp_d[exp_wr] = d0; exp_wr++;
        data_q.push_back(d0);
        start_cmd(1);
        repeat (3) begin
            tick();
            post("t3_no_write", {63'd0, wr_valid_o}, 64'd0);
            post("t3_no_accept", {63'd0, res_ready_o}, 64'd0);
        end
        post("t3_err_set", {63'd0, err_o}, 64'd1);
        addr_q.push_back(a0);
        run_until_done(200, 0);
        post("t3_err_sticky", {63'd0, err_o}, 64'd1);

        // 4: flush after two writes with three addresses still queued.
        load_cmd(5, 2);
        start_cmd(5);
        post("t4_err_cleared", {63'd0, err_o}, 64'd0);
        w0 = wr_cnt - 0;
        n  = 0;
        while (wr_cnt < w0 + 2 && n < 200) begin tick(); n++; end
        post("t4_two_writes", 64'(wr_cnt - w0), 64'd2);
        p0 = pop_cnt;
        post("t4_queued", 64'(addr_q.size()), 64'd3);
        reset_cmd_i = 1'b1;
        tick();
        reset_cmd_i = 1'b0;
        post("t4_wr_dropped", {63'd0, wr_valid_o}, 64'd0);
        run_until_done(50, 0);
        post("t4_flush_pops", 64'(pop_cnt - p0), 64'd3);
        post("t4_busy_after", {63'd0, busy_o}, 64'd0);

        // 5: zero-element command.
        start_cmd(0);
        post("t5_done", {63'd0, done_o}, 64'd1);
        post("t5_busy", {63'd0, busy_o}, 64'd0);
        post("t5_no_pop", {63'd0, af_rden_o}, 64'd0);
        post("t5_no_write", {63'd0, wr_valid_o}, 64'd0);
        tick();
        post("t5_done_cleared", {63'd0, done_o}, 64'd0);

        // 6: asynchronous reset in the middle of a command.
        res_rand = 1'b1;
        load_cmd(6, 6);
        start_cmd(6);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        post("t6_wr_valid", {63'd0, wr_valid_o}, 64'd0);
        post("t6_wr_addr", {54'd0, wr_addr_o}, 64'd0);
        post("t6_wr_data", {32'd0, wr_data_o}, 64'd0);
        post("t6_res_ready", {63'd0, res_ready_o}, 64'd0);
        post("t6_af_rden", {63'd0, af_rden_o}, 64'd0);
        post("t6_busy", {63'd0, busy_o}, 64'd0);
        post("t6_done", {63'd0, done_o}, 64'd0);
        addr_q.delete();
        data_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        wr_rand = 1'b1;
        load_cmd(4, 4);
        start_cmd(4);
        run_until_done(400, 0);

        // Random commands, including the maximum element count.
        for (int unsigned k = 0; k < 9; k++) begin
            n  = (k == 8) ? 255 : $urandom_range(1, 12);
            w0 = wr_cnt;
            load_cmd(n, n);
            start_cmd(n);
            run_until_done(3000, 0);
            post("rand_write_count", 64'(wr_cnt - w0), 64'(n));
            post("rand_busy_after", {63'd0, busy_o}, 64'd0);
            post("rand_err", {63'd0, err_o}, 64'd0);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
